// File: rtl/rescale_pkg.sv
// rescale_pkg: shared widths and helpers for the rescale/ReLU requantisation pipe.
//   DATA_W   signed accumulator width per lane
//   M0_W     signed fixed-point multiplier width
//   OUT_W    signed output width per lane
//   P_W      product width (DATA_W + M0_W), exact for any accumulator * M0
//   R_W      rounding-sum width (P_W + 1), so the rounding add never overflows
//   sat_clamp(r, relu_en) returns {sat_flag, y}
package rescale_pkg;

    localparam int DATA_W = 32;
    localparam int M0_W   = 8;
    localparam int OUT_W  = 8;
    localparam int P_W    = DATA_W + M0_W;
    localparam int R_W    = P_W + 1;

    localparam logic signed [R_W-1:0] OUT_MAX = R_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [R_W-1:0] OUT_MIN = R_W'(-(2 ** (OUT_W - 1)));

    // ReLU zeroing is not a clip event; only range clamping raises sat_flag.
    function automatic logic [OUT_W:0] sat_clamp(
        input logic signed [R_W-1:0] r,
        input logic                  relu_en
    );
        logic             sat;
        logic [OUT_W-1:0] y;
        sat = 1'b0;
        y   = '0;
        if (relu_en && r[R_W-1]) begin
            sat = 1'b0;
            y   = '0;
        end else if (r > OUT_MAX) begin
            sat = 1'b1;
            y   = OUT_MAX[OUT_W-1:0];
        end else if (r < OUT_MIN) begin
            sat = 1'b1;
            y   = OUT_MIN[OUT_W-1:0];
        end else begin
            sat = 1'b0;
            y   = r[OUT_W-1:0];
        end
        return {sat, y};
    endfunction

endpackage

// File: rtl/rescale_relu_pipe_lane.sv
// rescale_lane: one lane of the 3-stage requantisation datapath.
//   clk, rst          clock, synchronous active-high reset
//   en1/en2/en3       per-stage load enables (decided by the top's handshake)
//   relu_en           activation select, sampled as the beat enters S3
//   acc               signed accumulator input
//   y                 registered saturated output
//   sat               clip flag of the beat currently in S2 (counted by the top on S3 load)
module rescale_lane
    import rescale_pkg::*;
#(
    parameter int M0    = 59,
    parameter int SHIFT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en1,
    input  logic                     en2,
    input  logic                     en3,
    input  logic                     relu_en,
    input  logic signed [DATA_W-1:0] acc,
    output logic        [OUT_W-1:0]  y,
    output logic                     sat
);

    localparam logic signed [M0_W-1:0] M0_S   = M0_W'(M0);
    localparam int                     RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    // Half-LSB rounding constant; SHIFT=0 needs no rounding.
    localparam logic signed [R_W-1:0]  RND    = (SHIFT > 0) ? (R_W'(1) << RND_SH) : R_W'(0);

    logic signed [P_W-1:0] p_r;
    logic signed [R_W-1:0] r_r;
    logic signed [R_W-1:0] sum_s;
    logic        [OUT_W:0] clamp_s;

    // Rounding sum and activation/clamp for the S2/S3 boundary.
    always_comb begin
        sum_s   = R_W'(p_r) + RND;
        clamp_s = sat_clamp(r_r, relu_en);
        sat     = clamp_s[OUT_W];
    end

    // S1 multiply, S2 round/shift, S3 activate/saturate registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_r <= '0;
            r_r <= '0;
            y   <= '0;
        end else begin
            if (en1) p_r <= P_W'(acc) * P_W'(M0_S);
            if (en2) r_r <= sum_s >>> SHIFT;
            if (en3) y   <= clamp_s[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/rescale_relu_pipe.sv
// rescale_relu_pipe: LANES-wide requantisation (acc*M0 + round) >>> SHIFT,
// optional ReLU, signed saturation to OUT_W, 3-stage valid/ready pipeline.
//   clk, rst              clock, synchronous active-high reset
//   relu_en               1: negatives become 0; 0: signed saturate only
//   in_valid/in_ready     input handshake (in_ready has no path from in_valid)
//   in_data               lane i at [i*DATA_W +: DATA_W]
//   out_valid/out_ready   output handshake; out_data held while stalled
//   out_data              lane i at [i*OUT_W +: OUT_W], registered
//   sat_count             lanes clipped since reset, sticks at all-ones
module rescale_relu_pipe
    import rescale_pkg::*;
#(
    parameter int LANES = 4,
    parameter int M0    = 59,
    parameter int SHIFT = 8,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    relu_en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*OUT_W-1:0]  out_data,
    output logic [CNT_W-1:0]        sat_count
);

    localparam int             POP_W   = $clog2(LANES + 1);
    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic             v1_r, v2_r;
    logic             ld1_s, ld2_s, ld3_s;
    logic             en1_s, en2_s, en3_s;
    logic [LANES-1:0] sat_s;
    logic [POP_W-1:0] pop_s;
    logic [CNT_W:0]   cnt_sum_s;
    logic [CNT_W-1:0] cnt_next_s;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            rescale_lane #(
                .M0    (M0),
                .SHIFT (SHIFT)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .en1     (en1_s),
                .en2     (en2_s),
                .en3     (en3_s),
                .relu_en (relu_en),
                .acc     (in_data[gi*DATA_W +: DATA_W]),
                .y       (out_data[gi*OUT_W +: OUT_W]),
                .sat     (sat_s[gi])
            );
        end
    endgenerate

    // Stage load chain: a stage loads when empty or when its content moves on,
    // so bubbles collapse. Data registers only load on a real beat.
    always_comb begin
        ld3_s    = ~out_valid | out_ready;
        ld2_s    = ~v2_r | ld3_s;
        ld1_s    = ~v1_r | ld2_s;
        en1_s    = ld1_s & in_valid;
        en2_s    = ld2_s & v1_r;
        en3_s    = ld3_s & v2_r;
        in_ready = ld1_s;
    end

    // Popcount of clip flags and saturating counter increment.
    always_comb begin
        pop_s = '0;
        for (int i = 0; i < LANES; i++) begin
            pop_s = pop_s + POP_W'(sat_s[i]);
        end
        cnt_sum_s = {1'b0, sat_count} + (CNT_W + 1)'(pop_s);
        if (cnt_sum_s > CNT_MAX) begin
            cnt_next_s = CNT_MAX[CNT_W-1:0];
        end else begin
            cnt_next_s = cnt_sum_s[CNT_W-1:0];
        end
    end

    // Stage valids and the clip counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r      <= 1'b0;
            v2_r      <= 1'b0;
            out_valid <= 1'b0;
            sat_count <= '0;
        end else begin
            if (ld1_s) v1_r      <= in_valid;
            if (ld2_s) v2_r      <= v1_r;
            if (ld3_s) out_valid <= v2_r;
            if (en3_s) sat_count <= cnt_next_s;
        end
    end

endmodule
